// File: rtl/axi_stall_pkg.sv
// Shared constants and the LFSR step function for the AXI channel stall slices.
package axi_stall_pkg;

  localparam int unsigned LFSR_W = 16;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;
  localparam logic [LFSR_W-1:0] LFSR_DEFAULT_SEED = 16'hACE1;
  localparam int unsigned STALL_CNT_W = 32;

  // Right-shifting Galois step: the bit shifted out folds the taps back in.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    logic [LFSR_W-1:0] n;
    n = s >> 1;
    if (s[0]) begin
      n = n ^ LFSR_TAPS;
    end
    return n;
  endfunction

endpackage

// File: rtl/axi_stall_lfsr.sv
// Free-running 16-bit Galois LFSR; a zero seed is replaced by the default seed
// so the register can never lock up in the all-zero state.
module axi_stall_lfsr
  import axi_stall_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = LFSR_DEFAULT_SEED
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic [LFSR_W-1:0] state_o
);

  localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == '0) ? LFSR_DEFAULT_SEED : SEED;

  logic [LFSR_W-1:0] state_q;
  logic [LFSR_W-1:0] state_d;

  always_comb begin
    state_d = lfsr_next(state_q);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= SEED_EFF;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/axi_chan_stall_slice.sv
// Two-entry valid/ready slice for one AXI channel; defining AXI_STALL_INJECT_EN
// adds LFSR-driven suppression of out_valid_o plus a stall-cycle counter.
module axi_chan_stall_slice
  import axi_stall_pkg::*;
#(
  parameter int unsigned       DATA_WIDTH   = 64,
  parameter logic [LFSR_W-1:0] LFSR_SEED    = LFSR_DEFAULT_SEED,
  parameter int unsigned       STALL_THRESH = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   stall_en_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [DATA_WIDTH-1:0]  in_data_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [DATA_WIDTH-1:0]  out_data_o,
  output logic [STALL_CNT_W-1:0] stall_cnt_o
);

  logic [1:0][DATA_WIDTH-1:0] mem_q;
  logic [1:0][DATA_WIDTH-1:0] mem_d;
  logic                       wr_ptr_q;
  logic                       wr_ptr_d;
  logic                       rd_ptr_q;
  logic                       rd_ptr_d;
  logic [1:0]                 cnt_q;
  logic [1:0]                 cnt_d;
  logic                       held_q;
  logic                       held_d;
  logic                       push;
  logic                       pop;
  logic                       stall;

  // Every output below comes from registered state (plus the stall gate),
  // so no input-to-output combinational path exists for valid, data or ready.
  assign in_ready_o  = (cnt_q != 2'd2);
  assign out_valid_o = (cnt_q != 2'd0) && (held_q || !stall);
  assign out_data_o  = mem_q[rd_ptr_q];

  assign push = in_valid_i && in_ready_o;
  assign pop  = out_valid_o && out_ready_i;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    // A presented but unaccepted beat must stay presented whatever the LFSR does next.
    held_d   = out_valid_o && !out_ready_i;
    if (push) begin
      mem_d[wr_ptr_q] = in_data_i;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
      held_q   <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      held_q   <= held_d;
    end
  end

`ifdef AXI_STALL_INJECT_EN
  // Nine bits so a threshold of 256 stalls on every LFSR value.
  localparam logic [8:0] THRESH = 9'(STALL_THRESH);

  logic [LFSR_W-1:0]      lfsr;
  logic [STALL_CNT_W-1:0] stall_cnt_q;
  logic [STALL_CNT_W-1:0] stall_cnt_d;
  logic                   unused_lfsr_hi;

  axi_stall_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .state_o (lfsr)
  );

  assign unused_lfsr_hi = ^lfsr[LFSR_W-1:8];
  assign stall          = stall_en_i && ({1'b0, lfsr[7:0]} < THRESH);

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((cnt_q != 2'd0) && !out_valid_o && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  logic unused_stall_en;

  assign unused_stall_en = stall_en_i;
  assign stall           = 1'b0;
  assign stall_cnt_o     = '0;
`endif

endmodule

// File: tb/tb_axi_chan_stall_slice.sv
// Bench for axi_chan_stall_slice: queue-based reference model plus directed scenarios,
// on one slice with threshold 64 (zero seed) and one with threshold 256.
module tb_axi_chan_stall_slice;

  localparam int TH0 = 64;
  localparam int TH1 = 256;

  logic        clk;
  logic        rst;
  logic [1:0]  stall_en;
  logic [1:0]  in_valid;
  logic [1:0]  in_ready;
  logic [1:0]  out_valid;
  logic [1:0]  out_ready;
  logic [63:0] in_data  [2];
  logic [63:0] out_data [2];
  logic [31:0] scnt     [2];

  int vec  = 0;
  int miss = 0;
  int cyc  = 0;

  axi_chan_stall_slice #(.DATA_WIDTH(64), .LFSR_SEED(16'h0000), .STALL_THRESH(TH0)) d0 (
    .clk_i(clk), .rst_i(rst), .stall_en_i(stall_en[0]),
    .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]), .in_data_i(in_data[0]),
    .out_valid_o(out_valid[0]), .out_ready_i(out_ready[0]), .out_data_o(out_data[0]),
    .stall_cnt_o(scnt[0]));

  axi_chan_stall_slice #(.DATA_WIDTH(64), .LFSR_SEED(16'hACE1), .STALL_THRESH(TH1)) d1 (
    .clk_i(clk), .rst_i(rst), .stall_en_i(stall_en[1]),
    .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]), .in_data_i(in_data[1]),
    .out_valid_o(out_valid[1]), .out_ready_i(out_ready[1]), .out_data_o(out_data[1]),
    .stall_cnt_o(scnt[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    vec++;
    if (got !== exp) begin
      miss++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Reference model: buffered beats, the hold rule, the random sequence and the stall count.
  logic [15:0] mlfsr [2];
  int          msz   [2];
  logic [63:0] mdat  [2][2];
  bit          mheld [2];
  logic [31:0] mscnt [2];

  function automatic logic [15:0] step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  function automatic bit m_stall(input int i);
`ifdef AXI_STALL_INJECT_EN
    int th;
    th = (i == 0) ? TH0 : TH1;
    return stall_en[i] && (int'(mlfsr[i][7:0]) < th);
`else
    return (i < 0);
`endif
  endfunction

  function automatic bit m_ov(input int i);
    return (msz[i] != 0) && (mheld[i] || !m_stall(i));
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        msz[i] = 0; mheld[i] = 0; mscnt[i] = 0; mlfsr[i] = 16'hACE1;
      end
    end else begin
      cyc++;
      for (int i = 0; i < 2; i++) begin
        bit ov, pop, push;
        ov   = m_ov(i);
        pop  = ov && out_ready[i];
        push = in_valid[i] && (msz[i] != 2);
        if (msz[i] != 0 && !ov && mscnt[i] != 32'hFFFF_FFFF) mscnt[i]++;
        mheld[i] = ov && !out_ready[i];
        if (pop) begin mdat[i][0] = mdat[i][1]; msz[i]--; end
        if (push) begin mdat[i][msz[i]] = in_data[i]; msz[i]++; end
        mlfsr[i] = step(mlfsr[i]);
      end
    end
  end

  // Per-cycle compare, handshake logging, scoreboard and AXI stability checker.
  logic [63:0] sbq [$];
  logic [63:0] dlog0 [$];
  int          in_cyc  [2][32];
  int          out_cyc [2][32];
  bit          hold_p  [2];
  logic [63:0] hold_d  [2];
  bit          s4 = 0;
  int          elig = 0, stl = 0, s4_out = 0;

  always @(negedge clk) begin
    if (rst) begin
      hold_p[0] = 0; hold_p[1] = 0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("in_ready[%0d]", i), 64'(in_ready[i]), 64'(msz[i] != 2));
        chk($sformatf("out_valid[%0d]", i), 64'(out_valid[i]), 64'(m_ov(i)));
        if (m_ov(i)) chk($sformatf("out_data[%0d]", i), out_data[i], mdat[i][0]);
        chk($sformatf("stall_cnt[%0d]", i), 64'(scnt[i]), 64'(mscnt[i]));
        if (hold_p[i]) begin
          chk($sformatf("valid_held[%0d]", i), 64'(out_valid[i]), 64'd1);
          chk($sformatf("data_held[%0d]", i), out_data[i], hold_d[i]);
        end
        hold_p[i] = out_valid[i] && !out_ready[i];
        hold_d[i] = out_data[i];
        if (in_valid[i] && in_ready[i]) begin
          if (in_data[i] < 64'd32) in_cyc[i][in_data[i][4:0]] = cyc;
          if (i == 0) sbq.push_back(in_data[0]);
        end
        if (out_valid[i] && out_ready[i]) begin
          if (out_data[i] < 64'd32) out_cyc[i][out_data[i][4:0]] = cyc;
          if (i == 0) begin
            dlog0.push_back(out_data[0]);
            if (s4) s4_out++;
            if (sbq.size() == 0) begin
              vec++; miss++;
              $display("FAIL scoreboard: got %h with nothing outstanding", out_data[0]);
            end else begin
              chk("scoreboard_order", out_data[0], sbq.pop_front());
            end
          end
        end
      end
      if (s4 && msz[0] != 0 && !mheld[0]) begin
        elig++;
        if (!out_valid[0]) stl++;
      end
    end
  end

  task automatic send(input int i, input logic [63:0] d);
    int  n;
    bit  acc;
    n = 0; acc = 0;
    in_valid[i] = 1'b1; in_data[i] = d;
    while (!acc && n < 300) begin
      @(negedge clk); acc = in_ready[i]; n++;
      @(posedge clk); #1;
    end
    if (!acc) begin
      vec++; miss++;
      $display("FAIL send_timeout: inst %0d beat %h not accepted, got in_ready 0 required 1", i, d);
    end
    in_valid[i] = 1'b0;
  endtask

  task automatic scen_plain(input int i);
    stall_en[i] = (i == 1); out_ready[i] = 1'b1;
    for (int k = 1; k <= 16; k++) send(i, 64'(k));
    repeat (3) @(posedge clk);
    #1;
    for (int k = 1; k <= 16; k++) begin
      chk($sformatf("s1_latency[%0d] beat %0d", i, k), 64'(out_cyc[i][k] - in_cyc[i][k]), 64'd1);
      chk($sformatf("s1_order[%0d] beat %0d", i, k), 64'(out_cyc[i][k] - out_cyc[i][1]), 64'(k - 1));
      chk($sformatf("s1_b2b[%0d] beat %0d", i, k), 64'(in_cyc[i][k] - in_cyc[i][1]), 64'(k - 1));
    end
    chk($sformatf("s1_stall_cnt[%0d]", i), 64'(scnt[i]), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b0; stall_en = '0; in_valid = '0; out_ready = '0;
    in_data[0] = '0; in_data[1] = '0;
    #1 rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_in_ready", 64'(in_ready[i]), 64'd1);
      chk("rst_out_valid", 64'(out_valid[i]), 64'd0);
      chk("rst_out_data", out_data[i], 64'd0);
      chk("rst_stall_cnt", 64'(scnt[i]), 64'd0);
    end
    @(posedge clk); @(posedge clk); #2 rst = 1'b0;
    @(posedge clk); #1;

    // Plain slice, full throughput.
    scen_plain(0);
`ifndef AXI_STALL_INJECT_EN
    scen_plain(1);
`endif

    // Backpressure: two beats fill the slice, third waits.
    dlog0.delete();
    out_ready[0] = 1'b0;
    send(0, 64'h21); send(0, 64'h22);
    in_valid[0] = 1'b1; in_data[0] = 64'h23;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("s2_full_ready", 64'(in_ready[0]), 64'd0);
      chk("s2_valid", 64'(out_valid[0]), 64'd1);
      chk("s2_data_stable", out_data[0], 64'h21);
      @(posedge clk); #1;
    end
    out_ready[0] = 1'b1;
    send(0, 64'h23);
    repeat (4) @(posedge clk);
    #1;
    chk("s2_count", 64'(dlog0.size()), 64'd3);
    if (dlog0.size() == 3) begin
      chk("s2_beat1", dlog0[0], 64'h21);
      chk("s2_beat2", dlog0[1], 64'h22);
      chk("s2_beat3", dlog0[2], 64'h23);
    end

    // Always-stall slice: the beat waits until the enable drops.
    out_ready[1] = 1'b1; stall_en[1] = 1'b1;
    send(1, 64'h55);
`ifdef AXI_STALL_INJECT_EN
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("s3_suppressed", 64'(out_valid[1]), 64'd0);
      chk("s3_stall_cnt", 64'(scnt[1]), 64'(k));
    end
    @(posedge clk); #1;
    stall_en[1] = 1'b0;
    #1;
    chk("s3_same_cycle_valid", 64'(out_valid[1]), 64'd1);
    chk("s3_same_cycle_data", out_data[1], 64'h55);
`else
    @(negedge clk);
    chk("s3_plain_valid", 64'(out_valid[1]), 64'd1);
    chk("s3_plain_data", out_data[1], 64'h55);
    chk("s3_plain_cnt", 64'(scnt[1]), 64'd0);
`endif
    repeat (3) @(posedge clk);
    #1;

    // Random traffic with stalls enabled on the threshold-64 slice.
    stall_en[0] = 1'b1; s4 = 1; n = 0;
    begin
      int sent;
      bit acc;
      sent = 0;
      while (sent < 10000 && n < 80000) begin
        if (!in_valid[0] && $urandom_range(3) != 0) begin
          in_valid[0] = 1'b1; in_data[0] = {$urandom, $urandom};
        end
        out_ready[0] = ($urandom_range(3) != 0);
        @(negedge clk); acc = in_valid[0] && in_ready[0];
        @(posedge clk); #1;
        n++;
        if (acc) begin sent++; in_valid[0] = 1'b0; end
      end
      in_valid[0] = 1'b0; out_ready[0] = 1'b1; n = 0;
      while (sbq.size() != 0 && n < 500) begin @(posedge clk); n++; end
      #1;
      chk("s4_sent", 64'(sent), 64'd10000);
    end
    s4 = 0;
    chk("s4_delivered", 64'(s4_out), 64'd10000);
    chk("s4_leftover", 64'(sbq.size()), 64'd0);
`ifdef AXI_STALL_INJECT_EN
    chk("s4_stall_frac_lo", 64'(stl * 100 >= elig * 20), 64'd1);
    chk("s4_stall_frac_hi", 64'(stl * 100 <= elig * 30), 64'd1);
`endif

    // Reset with two beats buffered.
    stall_en[0] = 1'b0; out_ready[0] = 1'b0;
    send(0, 64'h31); send(0, 64'h32);
    #3 rst = 1'b1;
    #1;
    chk("s5_out_valid", 64'(out_valid[0]), 64'd0);
    chk("s5_in_ready", 64'(in_ready[0]), 64'd1);
    chk("s5_stall_cnt0", 64'(scnt[0]), 64'd0);
    chk("s5_stall_cnt1", 64'(scnt[1]), 64'd0);
    chk("s5_out_data", out_data[0], 64'd0);
    sbq.delete(); dlog0.delete();
    @(posedge clk); #2 rst = 1'b0;
    @(posedge clk); #1;
    out_ready[0] = 1'b1;
    send(0, 64'h41);
    repeat (3) @(posedge clk);
    #1;
    chk("s5_post_count", 64'(dlog0.size()), 64'd1);
    if (dlog0.size() >= 1) chk("s5_post_first", dlog0[0], 64'h41);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
